ram_burst_reader: RTL

//  Read-side initiator for the single-port BAND x DEPTH pixel RAM: on start, issues
//  LEN sequential reads from BASE (wrapping modulo DEPTH) and streams the words out on a

---
 rtl/ram_burst_reader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read initiator streaming RAM words through a 2-entry buffer
module ram_burst_reader #(
    parameter int BAND  = 64,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [AW-1:0]   i_base_addr,
    input  logic [AW:0]     i_length,
    input  logic            i_abort,
    output logic            o_mem_rd,
    output logic [AW-1:0]   o_mem_addr,
    input  logic [BAND-1:0] i_mem_rdata,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [BAND-1:0] o_out_data,
    output logic            o_out_last,
    output logic            o_busy,
    output logic            o_done
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   ONE       = (AW + 1)'(1);

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic [AW:0]     r_len;
    logic [AW:0]     r_issued;
    logic [AW:0]     r_delivered;
    logic            r_inflight;
    logic [1:0]      r_occ;
    logic [BAND-1:0] r_buf0;
    logic [BAND-1:0] r_buf1;

    logic            w_active;
    logic            w_pop;
    logic            w_push;
    logic            w_room;
    logic            w_issue;
    logic            w_issue_last;
    logic            w_head_last;
    logic [2:0]      w_fill;
    logic [2:0]      w_cap;

    // A word popped this cycle frees a slot, so the issue check counts it as room.
    assign w_active     = (r_state == S_READ) || (r_state == S_DRAIN);
    assign w_pop        = o_out_valid & i_out_ready;
    assign w_fill       = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_cap        = 3'd2 + {2'b00, w_pop};
    assign w_room       = w_fill < w_cap;
    assign w_issue      = (r_state == S_READ) && !i_abort && (r_issued < r_len) && w_room;
    assign w_issue_last = w_issue && ((r_issued + ONE) == r_len);
    assign w_push       = r_inflight && w_active && !i_abort;
    assign w_head_last  = (r_delivered == (r_len - ONE));

    assign o_out_valid  = (r_occ != 2'd0);
    assign o_out_data   = r_buf0;
    assign o_out_last   = o_out_valid && w_head_last;
    assign o_mem_addr   = r_addr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; abort wins over progress in the active states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (i_abort) begin
                    w_next = S_DONE;
                end else if (w_issue_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_next = S_DONE;
                end else if (w_pop && w_head_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM-driven outputs.
    always_comb begin
        o_mem_rd = 1'b0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        case (r_state)
            S_READ: begin
                o_mem_rd = w_issue;
                o_busy   = 1'b1;
            end
            S_DRAIN: o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Burst bookkeeping: latch request, advance the wrapping address, count issues and deliveries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if ((r_state == S_IDLE) && i_start) begin
                r_addr      <= i_base_addr;
                r_len       <= i_length;
                r_issued    <= '0;
                r_delivered <= '0;
            end else begin
                if (w_issue) begin
                    r_addr   <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
                    r_issued <= r_issued + ONE;
                end
                if (w_pop) begin
                    r_delivered <= r_delivered + ONE;
                end
            end
        end
    end

    // Two-entry output FIFO: buf0 is the head; abort drops everything including late RAM returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else if (w_active && i_abort) begin
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= i_mem_rdata;
                    end else begin
                        r_buf1 <= i_mem_rdata;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= i_mem_rdata;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
